cam_read: RTL and testbench

Camera capture stage sitting between the OV7670 pins and the frame buffer. It oversamples the camera's `pclk`/`href`/`vsync`/data bus in the system clock domain, assembles each two-byte RGB565 pixel, reduces it to RGB332, and issues one single-cycle write per pixel into the 160x120 dual-port buffer that the VGA driver reads.

---
 rtl/cam_pkg.sv | 19 +
 rtl/cam_sync.sv | 37 +++
 rtl/cam_read.sv | 139 +++++++++++++
 tb/tb_cam_read.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 capture path: image geometry defaults,
// capture FSM encoding and the RGB565 -> RGB332 reduction.
package cam_pkg;

  localparam int IMG_W_DEF = 160;
  localparam int IMG_H_DEF = 120;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_BYTE2 = 2'd2
  } cam_state_t;

  // byte1 = R4..R0 G5..G3, byte2 = G2..G0 B4..B0; keep the top bits of each channel
  function automatic logic [7:0] rgb565_to_332(input logic [7:0] b1, input logic [7:0] b2);
    return {b1[7:5], b1[2:0], b2[4:3]};
  endfunction

endpackage

// File: rtl/cam_sync.sv
// Two-flop synchronizer for a camera input bundle. The EW most significant bits
// get a third stage for rising-edge detect, the FW most significant of those also falling-edge.
module cam_sync #(
  parameter int N  = 11,
  parameter int EW = 2,
  parameter int FW = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    d,
  output logic [N-EW-1:0] lvl,
  output logic [EW-1:0]   rise,
  output logic [FW-1:0]   fall
);

  logic [N-1:0]  s1;
  logic [N-1:0]  s2;
  logic [EW-1:0] s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2[N-1 -: EW];
    end
  end

  // level bits come from s2 so they line up with the edge strobes
  assign lvl  = s2[N-EW-1:0];
  assign rise = s2[N-1 -: EW] & ~s3;
  assign fall = ~s2[N-1 -: FW] & s3[EW-1 -: FW];

endmodule

// File: rtl/cam_read.sv
// OV7670 capture stage: oversamples the camera bus in the clk domain, pairs
// bytes into RGB565 pixels and writes RGB332 pixels linearly into the frame buffer.
//
//   state    | meaning
//   ST_IDLE  | waiting for a vsync fall with capture_en high
//   ST_FRAME | inside a captured frame, expecting the first byte of a pixel
//   ST_BYTE2 | first byte held, expecting the second byte
module cam_read
  import cam_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cam_pclk,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic [7:0]    cam_px_data,
  input  logic          capture_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data,
  output logic          mem_wr,
  output logic          frame_done,
  output logic          overflow
);

  localparam int            NPIX = IMG_W * IMG_H;
  localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

  logic [8:0] bus_s;
  logic [1:0] rise_s;
  logic [0:0] fall_s;
  logic       pe, href_s, vs_re, vs_fe;
  logic [7:0] data_s;

  cam_sync #(.N(11), .EW(2), .FW(1)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    ({cam_vsync, cam_pclk, cam_href, cam_px_data}),
    .lvl  (bus_s),
    .rise (rise_s),
    .fall (fall_s)
  );

  assign vs_re  = rise_s[1];
  assign pe     = rise_s[0];
  assign vs_fe  = fall_s[0];
  assign href_s = bus_s[8];
  assign data_s = bus_s[7:0];

  cam_state_t    state;
  logic [7:0]    byte1;
  logic [7:0]    px;
  logic          wr_req, done_req, start_req;
  logic [AW-1:0] next_addr;
  logic          full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      byte1     <= '0;
      px        <= '0;
      wr_req    <= 1'b0;
      done_req  <= 1'b0;
      start_req <= 1'b0;
    end else begin
      wr_req    <= 1'b0;
      done_req  <= 1'b0;
      start_req <= 1'b0;
      case (state)
        ST_IDLE: begin
          // capture_en only matters here, so a mid-frame drop finishes the frame
          if (vs_fe && capture_en) begin
            start_req <= 1'b1;
            state     <= ST_FRAME;
          end
        end
        ST_FRAME: begin
          if (vs_re) begin
            done_req <= 1'b1;
            state    <= ST_IDLE;
          end else if (pe && href_s) begin
            byte1 <= data_s;
            state <= ST_BYTE2;
          end
        end
        ST_BYTE2: begin
          if (vs_re) begin
            done_req <= 1'b1;
            state    <= ST_IDLE;
          end else if (pe) begin
            // href low here means the line ended on an odd byte: drop it
            if (href_s) begin
              px     <= rgb565_to_332(byte1, data_s);
              wr_req <= 1'b1;
            end
            state <= ST_FRAME;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output stage: address counter, overflow and the registered buffer port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_wr     <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      next_addr  <= '0;
      full       <= 1'b0;
    end else begin
      mem_wr     <= 1'b0;
      frame_done <= done_req;
      if (start_req) begin
        mem_addr  <= '0;
        next_addr <= '0;
        full      <= 1'b0;
        overflow  <= 1'b0;
      end else if (wr_req) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          mem_wr   <= 1'b1;
          mem_addr <= next_addr;
          mem_data <= px;
          if (next_addr == LAST) full <= 1'b1;
          else                   next_addr <= next_addr + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_read.sv
// Self-checking bench for cam_read: drives OV7670-style frames with random data
// and compares buffer writes, frame_done and overflow against a pixel-level model.
module tb_cam_read;

  localparam int W  = 16;
  localparam int H  = 6;
  localparam int N  = W * H;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cam_pclk = 1'b0;
  logic          cam_vsync = 1'b1;
  logic          cam_href = 1'b0;
  logic [7:0]    cam_px_data = 8'h00;
  logic          capture_en = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          mem_wr;
  logic          frame_done;
  logic          overflow;

  cam_read #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cam_pclk    (cam_pclk),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_px_data (cam_px_data),
    .capture_en  (capture_en),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_wr      (mem_wr),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  int  rise_cyc = 0;
  wr_t obs_wr[$];
  wr_t exp_wr[$];
  int  obs_done[$];
  int  exp_done[$];
  bit  exp_ovf = 1'b0;
  bit  cap     = 1'b0;
  int  k       = 0;
  wr_t mon_w;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_wr) begin
      mon_w.addr = int'(mem_addr);
      mon_w.data = int'(mem_data);
      mon_w.cyc  = cyc;
      obs_wr.push_back(mon_w);
    end
    if (frame_done) obs_done.push_back(cyc);
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // RGB565 channels from the byte pair, then keep the top 3/3/2 bits
  function automatic int to332(input int b1, input int b2);
    int r, g, b;
    r = b1 >> 3;
    g = ((b1 & 7) << 3) | (b2 >> 5);
    b = b2 & 31;
    return ((r >> 2) << 5) | ((g >> 3) << 2) | (b >> 3);
  endfunction

  function automatic int gen_byte(input int mode, input int line, input int i);
    if (mode == 0) return 8'hE0;
    if (mode == 2 && line == 0 && i < 4) begin
      case (i)
        0: return 8'hF8;
        1: return 8'h1F;
        2: return 8'h07;
        default: return 8'hE0;
      endcase
    end
    return int'($urandom_range(0, 255));
  endfunction

  // One pclk period; changes to the bus happen only while pclk is low.
  task automatic tick();
    #20 cam_pclk = 1'b1;
    rise_cyc = cyc;
    #20 cam_pclk = 1'b0;
  endtask

  // en_mode: 0 capture_en low, 1 high before vsync fall, 2 rises in the vsync-fall cycle
  task automatic send_frame(input int lines, input int odd_line, input int en_mode,
                            input bit drop_mid, input int rst_line, input int dmode);
    int nb, b, b1;
    b1 = 0;
    capture_en = (en_mode == 1);
    cam_vsync  = 1'b0;
    #14;
    if (en_mode == 2) capture_en = 1'b1;
    #6;
    cap = (en_mode != 0);
    if (cap) begin
      k       = 0;
      exp_ovf = 1'b0;
    end
    tick();
    tick();
    for (int l = 0; l < lines; l++) begin
      if (drop_mid && l == 1) capture_en = 1'b0;
      nb = (l == odd_line) ? 2 * W + 1 : 2 * W;
      for (int i = 0; i < nb; i++) begin
        b           = gen_byte(dmode, l, i);
        cam_href    = 1'b1;
        cam_px_data = b[7:0];
        tick();
        if (i % 2 == 0) begin
          b1 = b;
        end else if (cap) begin
          if (k < N) begin
            wr_t e;
            e.addr = k;
            e.data = to332(b1, b);
            e.cyc  = rise_cyc + 4;
            exp_wr.push_back(e);
          end else begin
            exp_ovf = 1'b1;
          end
          k++;
        end
        if (l == rst_line && i == 6) begin
          rst = 1'b0;
          #1;
          check_eq("rst_mid mem_wr",     int'(mem_wr),     0);
          check_eq("rst_mid mem_addr",   int'(mem_addr),   0);
          check_eq("rst_mid mem_data",   int'(mem_data),   0);
          check_eq("rst_mid frame_done", int'(frame_done), 0);
          check_eq("rst_mid overflow",   int'(overflow),   0);
          #9 rst = 1'b1;
          #10;
          cap     = 1'b0;
          exp_ovf = 1'b0;
        end
      end
      cam_href    = 1'b0;
      cam_px_data = 8'($urandom_range(0, 255));
      tick();
      tick();
      tick();
    end
    cam_vsync = 1'b1;
    if (cap) exp_done.push_back(cyc + 4);
    tick();
    tick();
    tick();
  endtask

  task automatic check_frame(input string name);
    int n;
    check_eq({name, " writes"}, obs_wr.size(), exp_wr.size());
    n = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s px%0d addr", name, i), obs_wr[i].addr, exp_wr[i].addr);
      check_eq($sformatf("%s px%0d data", name, i), obs_wr[i].data, exp_wr[i].data);
      check_eq($sformatf("%s px%0d cycle", name, i), obs_wr[i].cyc, exp_wr[i].cyc);
    end
    check_eq({name, " frame_done count"}, obs_done.size(), exp_done.size());
    n = (obs_done.size() < exp_done.size()) ? obs_done.size() : exp_done.size();
    for (int i = 0; i < n; i++)
      check_eq({name, " frame_done cycle"}, obs_done[i], exp_done[i]);
    check_eq({name, " overflow"}, int'(overflow), int'(exp_ovf));
    obs_wr.delete();
    exp_wr.delete();
    obs_done.delete();
    exp_done.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    #10;
    check_eq("reset mem_addr",   int'(mem_addr),   0);
    check_eq("reset mem_data",   int'(mem_data),   0);
    check_eq("reset mem_wr",     int'(mem_wr),     0);
    check_eq("reset frame_done", int'(frame_done), 0);
    check_eq("reset overflow",   int'(overflow),   0);
    #30 rst = 1'b1;
    tick();
    tick();
    tick();

    send_frame(H, -1, 1, 1'b0, -1, 0);
    if (obs_wr.size() > 0)
      check_eq("const_e0 last addr", obs_wr[obs_wr.size()-1].addr, N - 1);
    check_frame("const_e0");

    send_frame(H, -1, 1, 1'b0, -1, 2);
    if (obs_wr.size() > 1) begin
      check_eq("pair F8_1F", obs_wr[0].data, 8'hE3);
      check_eq("pair 07_E0", obs_wr[1].data, 8'h1C);
    end
    check_frame("pairs");

    send_frame(H + 1, -1, 1, 1'b0, -1, 1);
    check_frame("overflow");

    send_frame(H, -1, 0, 1'b0, -1, 1);
    check_frame("disabled");

    send_frame(H, -1, 2, 1'b0, -1, 1);
    check_frame("en_boundary");

    send_frame(H, 2, 1, 1'b1, -1, 1);
    check_frame("odd_line");

    send_frame(H, -1, 1, 1'b0, 2, 1);
    check_frame("rst_mid");

    send_frame(H, -1, 1, 1'b0, -1, 1);
    check_frame("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
